alu_result_stage: RTL and testbench

Writeback stage directly downstream of the ALU. It captures the 64-bit ALU result into the Z register pair and derives zero/negative flags. It then delivers the result to the register-file/HI-LO write path as one or two 32-bit beats over a valid/ready handshake. MUL and DIV produce two beats (LO then HI); every other op produces one beat to the general-purpose destination.

---
 rtl/alu_result_stage_if.sv | 21 ++
 rtl/alu_result_stage.sv | 111 +++++++++++
 tb/tb_alu_result_stage.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_stage_if.sv
// Upstream capture handshake and downstream writeback beat channel of the ALU result stage.
interface alu_result_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  alu_op;
  logic [63:0] C;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [1:0]  res_dest;

  modport master (
    output in_valid, alu_op, C, res_ready,
    input  in_ready, res_valid, res_data, res_dest
  );

  modport slave (
    input  in_valid, alu_op, C, res_ready,
    output in_ready, res_valid, res_data, res_dest
  );
endinterface

// File: rtl/alu_result_stage.sv
// ALU writeback stage: captures the 64-bit result into Z, derives flags and emits
// one GPR beat or two LO/HI beats over a valid/ready handshake.
module alu_result_stage (
  input  logic                  clock,
  input  logic                  clear,
  alu_result_stage_if.slave     bus,
  output logic [63:0]           z_q,
  output logic                  flag_zero,
  output logic                  flag_neg,
  output logic                  illegal_op
);

  typedef enum logic [1:0] {S_IDLE, S_ONE, S_LO, S_HI} state_e;
  typedef enum logic [1:0] {OP_SINGLE, OP_DOUBLE, OP_ILLEGAL} op_class_e;

  state_e    state_q, state_d;
  op_class_e op_class;
  logic      is_mul;
  logic      accept;
  logic      flag_zero_q, flag_zero_d;
  logic      flag_neg_q, flag_neg_d;
  logic      illegal_q;
  logic [63:0] z_d;

  always_comb begin
    op_class = OP_ILLEGAL;
    case (bus.alu_op)
      5'b00001, 5'b00010, 5'b01000, 5'b00101,
      5'b00110, 5'b00111, 5'b00100: op_class = OP_SINGLE;
      5'b01001, 5'b00011:           op_class = OP_DOUBLE;
      default:                      op_class = OP_ILLEGAL;
    endcase
  end

  assign is_mul = (bus.alu_op == 5'b01001);

  // Only MUL flags look at the full 64 bits; DIV flags reflect the quotient alone.
  always_comb begin
    z_d         = bus.C;
    flag_zero_d = (bus.C[31:0] == 32'd0);
    flag_neg_d  = bus.C[31];
    if (op_class == OP_ILLEGAL) begin
      z_d         = '0;
      flag_zero_d = 1'b1;
      flag_neg_d  = 1'b0;
    end else if (is_mul) begin
      flag_zero_d = (bus.C == 64'd0);
      flag_neg_d  = bus.C[63];
    end
  end

  // in_ready depends combinationally on res_ready so the last beat and a new capture share a cycle.
  always_comb begin
    bus.in_ready = (state_q == S_IDLE) ||
                   (((state_q == S_ONE) || (state_q == S_HI)) && bus.res_ready);
    accept       = bus.in_valid && bus.in_ready;
    state_d      = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (op_class == OP_DOUBLE) ? S_LO : S_ONE;
      S_LO:   if (bus.res_ready) state_d = S_HI;
      S_ONE, S_HI: begin
        if (bus.res_ready) begin
          if (accept) state_d = (op_class == OP_DOUBLE) ? S_LO : S_ONE;
          else        state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.res_valid = (state_q != S_IDLE);
    bus.res_data  = '0;
    bus.res_dest  = 2'd0;
    case (state_q)
      S_ONE: bus.res_data = z_q[31:0];
      S_LO: begin
        bus.res_data = z_q[31:0];
        bus.res_dest = 2'd1;
      end
      S_HI: begin
        bus.res_data = z_q[63:32];
        bus.res_dest = 2'd2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= S_IDLE;
      z_q         <= '0;
      flag_zero_q <= 1'b0;
      flag_neg_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        z_q         <= z_d;
        flag_zero_q <= flag_zero_d;
        flag_neg_q  <= flag_neg_d;
        if (op_class == OP_ILLEGAL) illegal_q <= 1'b1;
      end
    end
  end

  assign flag_zero  = flag_zero_q;
  assign flag_neg   = flag_neg_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: directed scenarios plus a randomized backpressure run.
module tb_alu_result_stage;

  logic        clock = 1'b0;
  logic        clear;
  logic [63:0] z_q;
  logic        flag_zero, flag_neg, illegal_op;
  bit          rand_rdy = 1'b0;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [33:0] sb_q[$];
  bit          cap_pend = 1'b0;
  logic [63:0] exp_z;
  logic        exp_zero, exp_neg;
  logic        exp_ill = 1'b0;

  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam logic [4:0] OP_SUB = 5'b00010;
  localparam logic [4:0] OP_MUL = 5'b01001;
  localparam logic [4:0] OP_DIV = 5'b00011;

  alu_result_stage_if ifc ();

  alu_result_stage dut (
    .clock      (clock),
    .clear      (clear),
    .bus        (ifc),
    .z_q        (z_q),
    .flag_zero  (flag_zero),
    .flag_neg   (flag_neg),
    .illegal_op (illegal_op)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: what each accepted op must produce, derived from opcode and C.
  always @(negedge clock) begin
    logic [4:0]  op;
    logic [63:0] c;
    int unsigned pend;
    if (clear) begin
      sb_q.delete();
      cap_pend = 1'b0;
      exp_ill  = 1'b0;
    end else begin
      pend = sb_q.size();
      if (cap_pend) begin
        check("cap_z", z_q, exp_z);
        check("cap_zero", flag_zero, exp_zero);
        check("cap_neg", flag_neg, exp_neg);
        check("cap_illegal", illegal_op, exp_ill);
        cap_pend = 1'b0;
      end
      check("sb_valid", ifc.res_valid, pend != 0);
      check("sb_in_ready", ifc.in_ready, (pend == 0) || (pend == 1 && ifc.res_ready));
      if (ifc.res_valid && pend != 0) begin
        check("sb_data", ifc.res_data, sb_q[0][33:2]);
        check("sb_dest", ifc.res_dest, sb_q[0][1:0]);
        if (ifc.res_ready) void'(sb_q.pop_front());
      end
      if (ifc.in_valid && ifc.in_ready) begin
        op = ifc.alu_op;
        c  = ifc.C;
        case (op)
          OP_MUL, OP_DIV: begin
            sb_q.push_back({c[31:0], 2'd1});
            sb_q.push_back({c[63:32], 2'd2});
            exp_z    = c;
            exp_zero = (op == OP_MUL) ? (c == 64'd0) : (c[31:0] == 32'd0);
            exp_neg  = (op == OP_MUL) ? c[63] : c[31];
          end
          OP_ADD, OP_SUB, 5'b01000, 5'b00101, 5'b00110, 5'b00111, 5'b00100: begin
            sb_q.push_back({c[31:0], 2'd0});
            exp_z    = c;
            exp_zero = (c[31:0] == 32'd0);
            exp_neg  = c[31];
          end
          default: begin
            sb_q.push_back({32'd0, 2'd0});
            exp_z    = '0;
            exp_zero = 1'b1;
            exp_neg  = 1'b0;
            exp_ill  = 1'b1;
          end
        endcase
        cap_pend = 1'b1;
      end
    end
  end

  // Holds in_valid until the stage accepts; returns one step after the accepting edge.
  task automatic send(input logic [4:0] op, input logic [63:0] c);
    int unsigned n = 0;
    bit done = 1'b0;
    ifc.in_valid = 1'b1;
    ifc.alu_op   = op;
    ifc.C        = c;
    while (!done) begin
      @(negedge clock);
      if (ifc.in_ready) done = 1'b1;
      else if (n >= 50) begin
        check("send_timeout", 1'b0, 1'b1);
        done = 1'b1;
      end
      n++;
      @(posedge clock); #1;
      if (rand_rdy) ifc.res_ready = ($urandom_range(0, 3) != 0);
    end
    ifc.in_valid = 1'b0;
  endtask

  task automatic step;
    @(posedge clock); #1;
  endtask

  initial begin
    logic [63:0] rc;
    int unsigned w;
    clear         = 1'b1;
    ifc.in_valid  = 1'b1;
    ifc.alu_op    = OP_ADD;
    ifc.C         = 64'h5;
    ifc.res_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    clear        = 1'b0;
    ifc.in_valid = 1'b0;
    @(negedge clock);
    check("rst_valid", ifc.res_valid, 1'b0);
    check("rst_in_ready", ifc.in_ready, 1'b1);
    check("rst_z", z_q, 64'd0);
    check("rst_zero", flag_zero, 1'b0);
    check("rst_neg", flag_neg, 1'b0);
    check("rst_illegal", illegal_op, 1'b0);
    check("rst_data", ifc.res_data, 32'd0);
    check("rst_dest", ifc.res_dest, 2'd0);

    step();
    ifc.res_ready = 1'b1;
    send(OP_ADD, 64'h0);
    @(negedge clock);
    check("add_valid", ifc.res_valid, 1'b1);
    check("add_data", ifc.res_data, 32'd0);
    check("add_dest", ifc.res_dest, 2'd0);
    check("add_zero", flag_zero, 1'b1);
    check("add_neg", flag_neg, 1'b0);
    step();
    @(negedge clock);
    check("add_idle", ifc.res_valid, 1'b0);

    step();
    send(OP_MUL, 64'hFFFF_FFFF_FFFF_FFFE);
    @(negedge clock);
    check("mul_lo_data", ifc.res_data, 32'hFFFF_FFFE);
    check("mul_lo_dest", ifc.res_dest, 2'd1);
    check("mul_lo_in_ready", ifc.in_ready, 1'b0);
    check("mul_neg", flag_neg, 1'b1);
    check("mul_zero", flag_zero, 1'b0);
    step();
    @(negedge clock);
    check("mul_hi_data", ifc.res_data, 32'hFFFF_FFFF);
    check("mul_hi_dest", ifc.res_dest, 2'd2);
    step();

    ifc.res_ready = 1'b0;
    send(OP_DIV, 64'h0000_0003_0000_0007);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("bp_lo_data", ifc.res_data, 32'h0000_0007);
      check("bp_lo_dest", ifc.res_dest, 2'd1);
      check("bp_in_ready", ifc.in_ready, 1'b0);
      step();
    end
    ifc.res_ready = 1'b1;
    @(negedge clock);
    check("bp_rel_dest", ifc.res_dest, 2'd1);
    step();
    @(negedge clock);
    check("bp_hi_data", ifc.res_data, 32'h0000_0003);
    check("bp_hi_dest", ifc.res_dest, 2'd2);
    check("div_zero", flag_zero, 1'b0);
    check("div_neg", flag_neg, 1'b0);
    step();

    send(OP_MUL, 64'h0000_0001_0000_0002);
    ifc.in_valid = 1'b1;
    ifc.alu_op   = OP_SUB;
    ifc.C        = 64'h0000_0000_8000_0000;
    @(negedge clock);
    check("b2b_lo_in_ready", ifc.in_ready, 1'b0);
    step();
    @(negedge clock);
    check("b2b_hi_dest", ifc.res_dest, 2'd2);
    check("b2b_hi_in_ready", ifc.in_ready, 1'b1);
    step();
    ifc.in_valid = 1'b0;
    @(negedge clock);
    check("b2b_one_valid", ifc.res_valid, 1'b1);
    check("b2b_one_data", ifc.res_data, 32'h8000_0000);
    check("b2b_one_dest", ifc.res_dest, 2'd0);
    check("b2b_neg", flag_neg, 1'b1);
    step();

    send(5'b11111, 64'h1234);
    @(negedge clock);
    check("ill_data", ifc.res_data, 32'd0);
    check("ill_dest", ifc.res_dest, 2'd0);
    check("ill_flag", illegal_op, 1'b1);
    check("ill_zero", flag_zero, 1'b1);
    step();
    send(OP_ADD, 64'h7);
    @(negedge clock);
    check("ill_sticky", illegal_op, 1'b1);
    check("ill_next_data", ifc.res_data, 32'h7);
    step();

    send(OP_MUL, 64'hDEAD_BEEF_0000_0001);
    step();
    clear = 1'b1;
    @(negedge clock);
    check("clr_hi_dest", ifc.res_dest, 2'd2);
    step();
    clear = 1'b0;
    @(negedge clock);
    check("clr_valid", ifc.res_valid, 1'b0);
    check("clr_z", z_q, 64'd0);
    check("clr_zero", flag_zero, 1'b0);
    check("clr_neg", flag_neg, 1'b0);
    check("clr_illegal", illegal_op, 1'b0);
    check("clr_in_ready", ifc.in_ready, 1'b1);
    check("clr_data", ifc.res_data, 32'd0);
    step();

    rand_rdy = 1'b1;
    for (int t = 0; t < 300; t++) begin
      rc = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: rc = '0;
        1: rc[31:0] = '0;
        default: ;
      endcase
      if ($urandom_range(0, 1) == 0)
        send(($urandom_range(0, 1) == 0) ? OP_MUL : OP_DIV, rc);
      else
        send(5'($urandom_range(0, 31)), rc);
      if ($urandom_range(0, 4) == 0) begin
        step();
        ifc.res_ready = ($urandom_range(0, 3) != 0);
      end
    end
    rand_rdy      = 1'b0;
    ifc.res_ready = 1'b1;
    w = 0;
    while ((ifc.res_valid || sb_q.size() != 0) && w < 20) begin
      step();
      w++;
    end
    check("drain_timeout", w < 20, 1'b1);
    check("sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
